inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//  Instruction FIFO between fetch and decode. Captures each fetched word with its pc/pc1 on
//  in_valid and presents words to decode over a valid/ready handshake. Drives the registered
//  full back-pressure that fetch samples before issuing. flush drops all contents on redirect.
// PARAMETERS
//  INST_MEM_WIDTH  15  width of pc / pc1 (instruction-memory word address)
//  DEPTH_LOG2      2   log2 of entry count; DEPTH = 2**DEPTH_LOG2 (minimum 2)
// PORTS
//  CLK        in   1                clock, all state on posedge
//  reset      in   1                synchronous, active-high
//  in_valid   in   1                one-cycle pulse from fetch: in_* hold a new instruction
//  in_inst    in   32               instruction word
//  in_pc      in   INST_MEM_WIDTH   address of in_inst
//  in_pc1     in   INST_MEM_WIDTH   predicted next address for in_inst
//  full       out  1                registered back-pressure to fetch
//  out_valid  out  1                head entry valid toward decode
//  out_inst   out  32               head instruction
//  out_pc     out  INST_MEM_WIDTH   head pc
//  out_pc1    out  INST_MEM_WIDTH   head pc1
//  out_ready  in   1                decode accepts head when out_valid && out_ready
//  flush      in   1                synchronous discard of all entries (branch redirect)
//  count      out  DEPTH_LOG2+1     current occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset: wr_ptr = rd_ptr = 0, count = 0, full = 0, out_valid = 0, out_inst/pc/pc1 = 0,
//    overflow = 0. Takes precedence over all other inputs, including mid-transfer.
//  - Storage: DEPTH-entry circular array of {inst, pc, pc1}. Pointers are DEPTH_LOG2 bits
//    and wrap modulo DEPTH. count tracks occupancy explicitly.
//  - Push: in_valid && !flush writes in_* at wr_ptr, then wr_ptr+1.
//  - Pop: out_valid && out_ready && !flush advances rd_ptr. Pop while empty is ignored.
//  - Push + pop in the same cycle: both occur and count is unchanged. This is legal even at
//    count == DEPTH because the head leaves as the tail enters.
//  - full: registered, from next-state occupancy. full <= (count_next >= DEPTH-1).
//    This reserves one slot for the word fetch already has in flight when it samples full.
//  - Overflow: push at count == DEPTH without a simultaneous pop.
//    - The word is dropped; pointers and count are unchanged.
//    - Internal sticky flag overflow is set; it clears only on reset.
//  - Output (default): out_* are registered copies of the head entry.
//    - Latency from push into an empty queue to out_valid = 1 cycle.
//    - While out_valid && !out_ready, out_* hold stable.
//    - After a pop, the next entry (if any) is presented on the following cycle with no bubble.
//      Back-to-back pops sustain 1 word per cycle.
//  - Flush: the next cycle has count = 0, out_valid = 0 and full = 0; pointers reset to 0.
//    - in_valid and out_ready are ignored in the flush cycle; a coincident push is discarded.
//    - out_inst/pc/pc1 keep their last values; consumers qualify them with out_valid.
//  - count and full never disagree: full == (count >= DEPTH-1) on every cycle after reset.
// CONFIGURATION
//  IQ_BYPASS_EN defined: when the queue is empty, in_valid && !flush drives out_valid and
//    out_* combinationally from in_* in the same cycle (0-cycle latency).
//    - If out_ready is also high, the word bypasses storage and count stays 0.
//    - Otherwise the word is written and held on following cycles as a normal head.
//  IQ_BYPASS_EN undefined: no combinational path from in_* to out_*; out_* are purely
//    registered; latency is 1 cycle as above.
// TESTING
//  1. Reset held for 2 cycles with in_valid=1 -> count=0, full=0, out_valid=0, out_inst=0.
//  2. Push inst=0x00000013 pc=5 pc1=6, out_ready=0 -> next cycle out_valid=1, out_inst=0x13,
//     out_pc=5, out_pc1=6; all hold for 3 stalled cycles. (With IQ_BYPASS_EN, out_valid=1 in
//     the push cycle.)
//  3. DEPTH=4, out_ready=0, push 3 words -> full=1 after the 3rd push. 4th push accepted,
//     count=4. 5th push dropped, count stays 4, overflow=1.
//  4. count=4, in_valid=1 and out_ready=1 together -> count stays 4; oldest word leaves,
//     newest is stored. Drain 4 pops -> words appear in FIFO order across pointer wrap.
//  5. count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, full=0.
//     Following push appears as the head at out_pc.
//  6. Continuous push/pop for 20 cycles with out_ready=1 -> 1 word per cycle out, no loss,
//     full never asserts.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction FIFO between fetch and decode with registered full back-pressure and flush.
// Optional `IQ_BYPASS_EN: an empty queue forwards in_* to out_* combinationally.
module inst_queue #(
  parameter int INST_MEM_WIDTH = 15,
  parameter int DEPTH_LOG2     = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [31:0]               in_inst,
  input  logic [INST_MEM_WIDTH-1:0] in_pc,
  input  logic [INST_MEM_WIDTH-1:0] in_pc1,
  output logic                      full,
  output logic                      out_valid,
  output logic [31:0]               out_inst,
  output logic [INST_MEM_WIDTH-1:0] out_pc,
  output logic [INST_MEM_WIDTH-1:0] out_pc1,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [DEPTH_LOG2:0]       count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [31:0]               inst;
    logic [INST_MEM_WIDTH-1:0] pc;
    logic [INST_MEM_WIDTH-1:0] pc1;
  } entry_t;

  entry_t                  mem_q [DEPTH];
  entry_t                  head_q, head_d, in_ent;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_q, full_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    pop, push_req, push_wr, room, bypass_take;

  always_comb begin
    in_ent   = {in_inst, in_pc, in_pc1};
    pop      = out_valid_q && out_ready && !flush;
    push_req = in_valid && !flush;
`ifdef IQ_BYPASS_EN
    bypass_take = push_req && (count_q == '0) && out_ready;
`else
    bypass_take = 1'b0;
`endif
    // At full, a simultaneous pop frees the slot the new word lands in.
    room       = (count_q != DEPTH_C) || pop;
    push_wr    = push_req && room && !bypass_take;
    overflow_d = overflow_q | (push_req && !room);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_wr, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    full_d      = (count_d >= DEPTH_C - CNT_ONE);
    out_valid_d = (count_d != '0);

    // Next head may be the slot written this very cycle, so forward it from in_*.
    head_d = head_q;
    if (count_d != '0) begin
      if (push_wr && (wr_ptr_q == rd_ptr_d)) head_d = in_ent;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      head_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      head_q      <= head_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset && push_wr) mem_q[wr_ptr_q] <= in_ent;
  end

  assign full  = full_q;
  assign count = count_q;

`ifdef IQ_BYPASS_EN
  logic bypass;
  assign bypass    = push_req && (count_q == '0);
  assign out_valid = out_valid_q | bypass;
  assign out_inst  = bypass ? in_inst : head_q.inst;
  assign out_pc    = bypass ? in_pc   : head_q.pc;
  assign out_pc1   = bypass ? in_pc1  : head_q.pc1;
`else
  assign out_valid = out_valid_q;
  assign out_inst  = head_q.inst;
  assign out_pc    = head_q.pc;
  assign out_pc1   = head_q.pc1;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue (default build, DEPTH=4): directed scenarios then random traffic.
module tb_inst_queue;

  localparam int W     = 15;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          reset, in_valid, out_ready, flush;
  logic [31:0]   in_inst;
  logic [W-1:0]  in_pc, in_pc1;
  logic          full, out_valid;
  logic [31:0]   out_inst;
  logic [W-1:0]  out_pc, out_pc1;
  logic [2:0]    count;

  inst_queue #(.INST_MEM_WIDTH(W), .DEPTH_LOG2(2)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_pc1(in_pc1), .full(full), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc1(out_pc1),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]  inst;
    logic [W-1:0] pc;
    logic [W-1:0] pc1;
  } word_t;

  word_t sb[$];
  int    mcnt = 0, mcnt_nxt = 0;
  bit    movf = 0;
  bit    mon_en = 0;
  int    total = 0, bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: occupancy/full/valid every cycle, head contents against the oldest expected word.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("count", 64'(count), 64'(mcnt));
      chk("full", 64'(full), 64'(mcnt >= DEPTH - 1));
      chk("out_valid", 64'(out_valid), 64'(mcnt != 0));
      if (out_valid && !reset) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL head: got out_valid=1 expected no pending word at %0t", $time);
        end else begin
          chk("out_inst", 64'(out_inst), 64'(sb[0].inst));
          chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
          chk("out_pc1", 64'(out_pc1), 64'(sb[0].pc1));
          if (out_ready && !flush) void'(sb.pop_front());
        end
      end
    end
  end

  // Drive one cycle of inputs and advance the FIFO reference model.
  task automatic step(input logic v, input logic [31:0] i, input logic [W-1:0] p,
                      input logic [W-1:0] p1, input logic r, input logic f, input logic rs);
    bit pop_m, acc;
    word_t w;
    reset = rs; in_valid = v; in_inst = i; in_pc = p; in_pc1 = p1;
    out_ready = r; flush = f;
    if (rs) begin
      mcnt_nxt = 0;
      movf = 0;
    end else if (f) begin
      mcnt_nxt = 0;
    end else begin
      pop_m = (mcnt > 0) && r;
      acc   = v && ((mcnt < DEPTH) || pop_m);
      if (v && !acc) movf = 1;
      if (acc) begin
        w.inst = i; w.pc = p; w.pc1 = p1;
        sb.push_back(w);
      end
      mcnt_nxt = mcnt + int'(acc) - int'(pop_m);
    end
    @(posedge CLK);
    mcnt = mcnt_nxt;
    if (rs || f) sb.delete();
    #1;
  endtask

  task automatic push(input logic [31:0] i, input int p, input logic r);
    step(1'b1, i, W'(p), W'(p + 1), r, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 32'h0, '0, '0, r, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_pc1 = '0;
    out_ready = 1'b0; flush = 1'b0;
    @(posedge CLK);
    #1;
    // Reset held two cycles with in_valid high.
    step(1'b1, 32'hDEAD_BEEF, 15'd9, 15'd10, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hDEAD_BEEF, 15'd9, 15'd10, 1'b0, 1'b0, 1'b1);
    chk("rst_out_inst", 64'(out_inst), 64'h0);
    chk("rst_out_pc", 64'(out_pc), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    mon_en = 1;

    // Single push, then stall three cycles.
    step(1'b1, 32'h0000_0013, 15'd5, 15'd6, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);

    // Fill to DEPTH, then one overflowing push.
    push(32'h1000_0001, 20, 1'b0);
    push(32'h1000_0002, 30, 1'b0);
    push(32'h1000_0003, 40, 1'b0);
    push(32'h1000_0004, 50, 1'b0);
    chk("ovf_flag", 64'(dut.overflow_q), 64'(movf));

    // Push and pop at full, then drain across the pointer wrap.
    push(32'h2000_0001, 60, 1'b1);
    repeat (5) idle(1'b1);

    // Flush at count 3 with a coincident push, then a fresh head.
    for (int k = 0; k < 3; k++) push(32'h3000_0000 + k, 70 + k, 1'b0);
    step(1'b1, 32'h3333_3333, 15'd99, 15'd98, 1'b1, 1'b1, 1'b0);
    push(32'h4000_0001, 123, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Sustained streaming.
    for (int k = 0; k < 20; k++) push(32'h5000_0000 + k, 200 + k, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) < 60, $urandom, W'($urandom), W'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4, 1'b0);
    end
    repeat (6) idle(1'b1);
    chk("ovf_sticky", 64'(dut.overflow_q), 64'(movf));
    chk("drained", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
